// File: rtl/bus_change_arb.sv
// rtl/bus_change_arb.sv - change-capture arbiter serialising NCH synchronous buses onto one stream
module bus_change_arb #(
   parameter int DWIDTH = 8,
   parameter int NCH    = 4,
   parameter int POLICY = 0,
   localparam int CHW   = $clog2(NCH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NCH*DWIDTH-1:0] din,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DWIDTH-1:0]     out_data,
   output logic [CHW-1:0]        out_chan,
   output logic [NCH-1:0]        lost,
   output logic [NCH-1:0]        lost_stky,
   input  logic [NCH-1:0]        lost_clr
);

   logic [DWIDTH-1:0] din_w [NCH];
   logic [DWIDTH-1:0] prev  [NCH];
   logic [DWIDTH-1:0] hold  [NCH];
   logic [NCH-1:0]    pend;
   logic [NCH-1:0]    change;
   logic [NCH-1:0]    granted;
   logic [NCH-1:0]    lost_set;
   logic [CHW-1:0]    ptr;
   logic [CHW-1:0]    gnt_idx;
   logic [CHW-1:0]    cand;
   logic              gnt_any;
   logic              out_free;
   logic              grant;

   // split the flat bus into per-channel words
   for (genvar g = 0; g < NCH; g++) begin : g_split
      assign din_w[g] = din[g*DWIDTH +: DWIDTH];
   end

   assign out_free = !out_valid || out_ready;
   assign grant    = out_free && gnt_any;

   // change detect, grant decode and loss decode per channel
   always_comb begin
      change   = '0;
      granted  = '0;
      lost_set = '0;
      for (int i = 0; i < NCH; i++) begin
         change[i]   = (din_w[i] != prev[i]);
         granted[i]  = grant && (gnt_idx == CHW'(i));
         // a grant on this edge frees the slot, so a coincident change is not a loss
         lost_set[i] = change[i] && pend[i] && !granted[i];
      end
   end

   // round-robin search for the first pending channel after the last winner
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 1; k <= NCH; k++) begin
         cand = CHW'((int'(ptr) + k) % NCH);
         if (!gnt_any && pend[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   // per-channel previous value, hold register and pending flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            prev[i] <= '0;
            hold[i] <= '0;
         end
         pend <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            prev[i] <= din_w[i];
            if (change[i]) begin
               if (!pend[i] || granted[i]) begin
                  hold[i] <= din_w[i];
                  pend[i] <= 1'b1;
               end else if (POLICY == 1) begin
                  hold[i] <= din_w[i];
               end
            end else if (granted[i]) begin
               pend[i] <= 1'b0;
            end
         end
      end
   end

   // loss pulse and sticky loss; a new loss beats a same-edge clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lost      <= '0;
         lost_stky <= '0;
      end else begin
         lost      <= lost_set;
         lost_stky <= lost_set | (lost_stky & ~lost_clr);
      end
   end

   // output register loads the granted word whenever it is free
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         ptr       <= CHW'(NCH - 1);
      end else if (out_free) begin
         if (gnt_any) begin
            out_valid <= 1'b1;
            out_data  <= hold[gnt_idx];
            out_chan  <= gnt_idx;
            ptr       <= gnt_idx;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bus_change_arb.sv
// tb/tb_bus_change_arb.sv - self-checking bench for bus_change_arb, DROP and OVERWRITE instances
module tb_bus_change_arb;
   localparam int DW = 8;
   localparam int N  = 4;
   localparam int CW = 2;

   logic          clk       = 1'b0;
   logic          rst       = 1'b1;
   logic [N*DW-1:0] din     = '0;
   logic          out_ready = 1'b0;
   logic [N-1:0]  lost_clr  = '0;

   logic          ov  [2];
   logic [DW-1:0] od  [2];
   logic [CW-1:0] oc  [2];
   logic [N-1:0]  lst [2];
   logic [N-1:0]  stk [2];

   int n_chk  = 0;
   int n_fail = 0;

   logic [CW+DW-1:0] acc0 [$];
   logic [CW+DW-1:0] acc1 [$];

   bus_change_arb #(.DWIDTH(DW), .NCH(N), .POLICY(0)) u_drop (
      .clk(clk), .rst(rst), .din(din), .out_valid(ov[0]), .out_ready(out_ready),
      .out_data(od[0]), .out_chan(oc[0]), .lost(lst[0]), .lost_stky(stk[0]), .lost_clr(lost_clr));

   bus_change_arb #(.DWIDTH(DW), .NCH(N), .POLICY(1)) u_ovw (
      .clk(clk), .rst(rst), .din(din), .out_valid(ov[1]), .out_ready(out_ready),
      .out_data(od[1]), .out_chan(oc[1]), .lost(lst[1]), .lost_stky(stk[1]), .lost_clr(lost_clr));

   always #5 clk = ~clk;

   // behavioural model: one slot per channel plus one output slot, per policy
   logic [DW-1:0] m_prev [2][N];
   logic [DW-1:0] m_hold [2][N];
   bit            m_pend [2][N];
   bit            m_ov   [2];
   logic [DW-1:0] m_od   [2];
   int            m_oc   [2];
   int            m_ptr  [2];
   logic [N-1:0]  m_lost [2];
   logic [N-1:0]  m_stky [2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < N; i++) begin
            m_prev[p][i] = '0;
            m_hold[p][i] = '0;
            m_pend[p][i] = 1'b0;
         end
         m_ov[p]   = 1'b0;
         m_od[p]   = '0;
         m_oc[p]   = 0;
         m_ptr[p]  = N - 1;
         m_lost[p] = '0;
         m_stky[p] = '0;
      end
   endtask

   task automatic model_step(input int p);
      bit            free;
      int            g;
      int            c;
      logic [N-1:0]  ln;
      logic [DW-1:0] w;
      free = !m_ov[p] || out_ready;
      g = -1;
      for (int k = 1; k <= N; k++) begin
         c = (m_ptr[p] + k) % N;
         if (g < 0 && m_pend[p][c]) g = c;
      end
      // the grant empties the slot first, then changes fill empty slots
      if (free) begin
         if (g >= 0) begin
            m_od[p]      = m_hold[p][g];
            m_oc[p]      = g;
            m_ov[p]      = 1'b1;
            m_ptr[p]     = g;
            m_pend[p][g] = 1'b0;
         end else begin
            m_ov[p] = 1'b0;
         end
      end
      ln = '0;
      for (int i = 0; i < N; i++) begin
         w = din[i*DW +: DW];
         if (w != m_prev[p][i]) begin
            if (!m_pend[p][i]) begin
               m_hold[p][i] = w;
               m_pend[p][i] = 1'b1;
            end else begin
               ln[i] = 1'b1;
               if (p == 1) m_hold[p][i] = w;
            end
         end
         m_prev[p][i] = w;
      end
      m_lost[p] = ln;
      m_stky[p] = ln | (m_stky[p] & ~lost_clr);
   endtask

   // model advance on every edge, async reset honoured immediately
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else begin
         model_step(0);
         model_step(1);
      end
   end

   // compare DUT against model mid-cycle and record accepted words
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         for (int p = 0; p < 2; p++) begin
            chk($sformatf("out_valid p%0d", p), 32'(ov[p]), 32'(m_ov[p]));
            chk($sformatf("out_data p%0d", p), 32'(od[p]), 32'(m_od[p]));
            chk($sformatf("out_chan p%0d", p), 32'(oc[p]), 32'(m_oc[p]));
            chk($sformatf("lost p%0d", p), 32'(lst[p]), 32'(m_lost[p]));
            chk($sformatf("lost_stky p%0d", p), 32'(stk[p]), 32'(m_stky[p]));
            if (ov[p] && out_ready) begin
               if (p == 0) acc0.push_back({oc[p], od[p]});
               else        acc1.push_back({oc[p], od[p]});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int i, input logic [DW-1:0] v);
      din[i*DW +: DW] = v;
   endtask

   task automatic do_reset();
      din = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic clear_q();
      acc0.delete();
      acc1.delete();
   endtask

   task automatic q_expect(input int p, input int idx, input logic [CW+DW-1:0] e);
      logic [CW+DW-1:0] a;
      a = '1;
      if (p == 0) begin
         if (idx < acc0.size()) a = acc0[idx];
      end else begin
         if (idx < acc1.size()) a = acc1[idx];
      end
      chk($sformatf("stream p%0d[%0d]", p, idx), 32'(a), 32'(e));
   endtask

   task automatic q_size(input int s0, input int s1);
      chk("stream size p0", 32'(acc0.size()), 32'(s0));
      chk("stream size p1", 32'(acc1.size()), 32'(s1));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // quiet inputs after reset
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("idle valid p0", 32'(ov[0]), 32'd0);
         chk("idle valid p1", 32'(ov[1]), 32'd0);
      end
      chk("idle data", 32'(od[0]), 32'd0);
      chk("idle lost_stky", 32'(stk[1]), 32'd0);

      // single change on ch2
      out_ready = 1'b1;
      set_ch(2, 8'hA5);
      tick();
      chk("ch2 capture edge valid", 32'(ov[0]), 32'd0);
      tick();
      chk("ch2 valid", 32'(ov[0]), 32'd1);
      chk("ch2 chan", 32'(oc[0]), 32'd2);
      chk("ch2 data", 32'(od[1]), 32'hA5);
      tick();
      chk("ch2 one cycle", 32'(ov[0]), 32'd0);

      // all channels together, then channels 1 and 3
      do_reset();
      clear_q();
      set_ch(0, 8'h10); set_ch(1, 8'h21); set_ch(2, 8'h32); set_ch(3, 8'h43);
      repeat (7) tick();
      q_size(4, 4);
      for (int p = 0; p < 2; p++) begin
         q_expect(p, 0, {2'd0, 8'h10});
         q_expect(p, 1, {2'd1, 8'h21});
         q_expect(p, 2, {2'd2, 8'h32});
         q_expect(p, 3, {2'd3, 8'h43});
      end
      clear_q();
      set_ch(3, 8'h77); set_ch(1, 8'h55);
      repeat (5) tick();
      q_size(2, 2);
      q_expect(0, 0, {2'd1, 8'h55});
      q_expect(0, 1, {2'd3, 8'h77});

      // stalled consumer, three changes on ch1
      out_ready = 1'b0;
      clear_q();
      set_ch(1, 8'h11); tick();
      set_ch(1, 8'h22); tick();
      set_ch(1, 8'h33); tick();
      chk("lost pulse p0", 32'(lst[0]), 32'h2);
      chk("lost pulse p1", 32'(lst[1]), 32'h2);
      tick();
      chk("lost once", 32'(lst[0]), 32'h0);
      chk("lost_stky set", 32'(stk[0]), 32'h2);
      out_ready = 1'b1;
      repeat (4) tick();
      q_size(2, 2);
      q_expect(0, 0, {2'd1, 8'h11});
      q_expect(0, 1, {2'd1, 8'h22});
      q_expect(1, 0, {2'd1, 8'h11});
      q_expect(1, 1, {2'd1, 8'h33});

      // grant coinciding with a new change on ch0
      clear_q();
      set_ch(0, 8'h61); tick();
      set_ch(0, 8'h62); tick();
      chk("coincide lost p0", 32'(lst[0]), 32'h0);
      chk("coincide lost p1", 32'(lst[1]), 32'h0);
      repeat (4) tick();
      q_size(2, 2);
      q_expect(0, 0, {2'd0, 8'h61});
      q_expect(1, 1, {2'd0, 8'h62});

      // clear racing a new loss, then a lone clear
      out_ready = 1'b0;
      set_ch(1, 8'h71); tick();
      set_ch(1, 8'h72); tick();
      set_ch(1, 8'h73); lost_clr = 4'b0010; tick();
      lost_clr = '0;
      chk("clr vs set lost", 32'(lst[0]), 32'h2);
      chk("clr vs set stky", 32'(stk[0]), 32'h2);
      tick();
      chk("stky holds", 32'(stk[1]), 32'h2);
      lost_clr = 4'b0010; tick();
      lost_clr = '0;
      chk("lone clr p0", 32'(stk[0]), 32'h0);
      chk("lone clr p1", 32'(stk[1]), 32'h0);
      out_ready = 1'b1;
      repeat (4) tick();

      // async reset while a word is stalled at the output
      out_ready = 1'b0;
      set_ch(3, 8'h99);
      tick();
      tick();
      chk("stall valid", 32'(ov[0]), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async rst valid p0", 32'(ov[0]), 32'd0);
      chk("async rst valid p1", 32'(ov[1]), 32'd0);
      chk("async rst data", 32'(od[0]), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // randomized traffic against the model
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 3) == 0) set_ch(i, DW'($urandom_range(0, 3)));
         out_ready = ($urandom_range(0, 99) < ((cyc < 1500) ? 75 : 30));
         lost_clr  = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
